// File: rtl/dl_trans_pkg.sv
// Shared definitions for the downlink TDM transmit multiplexer: bandwidth codes,
// antenna-period multiplier lookup and lock state encoding.
package dl_trans_pkg;

    localparam logic [3:0] BW_10M = 4'h1;
    localparam logic [3:0] BW_20M = 4'h2;
    localparam logic [3:0] BW_30M = 4'h3;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_e;

    // Antenna period expressed in TDM rounds for a given bandwidth code.
    function automatic logic [2:0] ant_mult(input logic [3:0] code);
        case (code)
            BW_10M:         return 3'd4;
            BW_20M, BW_30M: return 3'd2;
            default:        return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dl_trans_dly.sv
// Fixed-depth shift-register delay for one carrier's sample stream.
// Data path carries no reset; contents are don't-care until the stream fills it.
module dl_trans_dly #(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i) begin
        sr_q[0] <= d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/dl_trans_mc.sv
// Downlink frequency-domain TDM multiplexer with frame-aligned antenna-slot strobe.
// Optional misaligned-frame detector enabled by defining DL_TRANS_FRAM_CHK_EN.
module dl_trans_mc
    import dl_trans_pkg::*;
#(
    parameter int unsigned NUM_CARR = 2,
    parameter int unsigned BLK_LEN  = 4,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                       clk_491,
    input  logic                       rst_491_n,
    input  logic [31:0]                i_bandwidth_sel,
    input  logic [NUM_CARR-1:0]        i_carr_en,
    input  logic [NUM_CARR*DATA_W-1:0] i_freq_fdata,
    input  logic                       i_freq_ffram,
    output logic                       o_freq_txant,
    output logic                       o_freq_tfram,
    output logic [DATA_W-1:0]          o_freq_tdata,
    output logic                       o_locked,
    output logic                       o_fram_err
);

    localparam int unsigned RND    = NUM_CARR * BLK_LEN;
    localparam int unsigned CNT_W  = $clog2(4 * RND);
    localparam int unsigned PH_W   = $clog2(RND);
    localparam int unsigned BLK_SH = $clog2(BLK_LEN);
    localparam int unsigned CAR_W  = $clog2(NUM_CARR);

    state_e             state_q, state_d;
    logic               fram_d1_q;
    logic               tfram_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ant_last_q, ant_last_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic               txant_q, txant_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic [CAR_W-1:0]   car_idx;
    logic [DATA_W-1:0]  dly_out [NUM_CARR];
    logic               unused_bw;

    assign unused_bw = ^i_bandwidth_sel[31:4];

    // Carrier k is delayed by k blocks so that every carrier's window lines up
    // with the samples that arrived just before the round started.
    for (genvar k = 0; k < NUM_CARR; k++) begin : g_carr
        dl_trans_dly #(
            .DEPTH  (1 + k * BLK_LEN),
            .DATA_W (DATA_W)
        ) u_dly (
            .clk_i (clk_491),
            .d_i   (i_freq_fdata[k*DATA_W +: DATA_W]),
            .q_o   (dly_out[k])
        );
    end

    // ph_q tracks cnt mod RND; valid because the antenna period is a whole number
    // of rounds and both counters clear together.
    assign car_idx = CAR_W'(ph_q >> BLK_SH);

    always_comb begin
        state_d    = state_q;
        ant_last_d = ant_last_q;
        cnt_d      = cnt_q + 1'b1;
        ph_d       = ph_q + 1'b1;
        if (cnt_q == ant_last_q) begin
            cnt_d = '0;
        end
        if (ph_q == PH_W'(RND - 1)) begin
            ph_d = '0;
        end
        if (fram_d1_q) begin
            state_d    = ST_LOCKED;
            ant_last_d = CNT_W'(32'(ant_mult(i_bandwidth_sel[3:0])) * RND - 32'd1);
            cnt_d      = '0;
            ph_d       = '0;
        end
        txant_d = (state_q == ST_LOCKED) && (cnt_q == ant_last_q);
    end

    always_comb begin
        tdata_d = '0;
        if ((state_q == ST_LOCKED) && i_carr_en[car_idx]) begin
            tdata_d = dly_out[car_idx];
        end
    end

    always_ff @(posedge clk_491 or negedge rst_491_n) begin
        if (!rst_491_n) begin
            state_q    <= ST_UNLOCKED;
            fram_d1_q  <= 1'b0;
            tfram_q    <= 1'b0;
            cnt_q      <= '0;
            ph_q       <= '0;
            ant_last_q <= CNT_W'(RND - 1);
            txant_q    <= 1'b0;
            tdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            fram_d1_q  <= i_freq_ffram;
            tfram_q    <= fram_d1_q;
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            ant_last_q <= ant_last_d;
            txant_q    <= txant_d;
            tdata_q    <= tdata_d;
        end
    end

`ifdef DL_TRANS_FRAM_CHK_EN
    logic err_q, err_d;

    // A frame that lands anywhere but the last slot of the period is misaligned.
    assign err_d = fram_d1_q && (state_q == ST_LOCKED) && (cnt_q != ant_last_q);

    always_ff @(posedge clk_491 or negedge rst_491_n) begin
        if (!rst_491_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_fram_err = err_q;
`else
    assign o_fram_err = 1'b0;
`endif

    assign o_freq_txant = txant_q;
    assign o_freq_tfram = tfram_q;
    assign o_freq_tdata = tdata_q;
    assign o_locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_dl_trans_mc.sv
// Scoreboard bench for dl_trans_mc: a cycle-indexed reference model computes each
// cycle's expected outputs from recorded inputs; a negedge monitor pops and compares.
module tb_dl_trans_mc;

    localparam int NUM_CARR = 2;
    localparam int BLK_LEN  = 4;
    localparam int DATA_W   = 32;
    localparam int RND      = NUM_CARR * BLK_LEN;
    localparam int MAXC     = 2048;

    logic                       clk_491 = 1'b0;
    logic                       rst_491_n = 1'b0;
    logic [31:0]                i_bandwidth_sel = '0;
    logic [NUM_CARR-1:0]        i_carr_en = '1;
    logic [NUM_CARR*DATA_W-1:0] i_freq_fdata = '0;
    logic                       i_freq_ffram = 1'b0;
    logic                       o_freq_txant;
    logic                       o_freq_tfram;
    logic [DATA_W-1:0]          o_freq_tdata;
    logic                       o_locked;
    logic                       o_fram_err;

    dl_trans_mc #(
        .NUM_CARR (NUM_CARR),
        .BLK_LEN  (BLK_LEN),
        .DATA_W   (DATA_W)
    ) dut (
        .clk_491         (clk_491),
        .rst_491_n       (rst_491_n),
        .i_bandwidth_sel (i_bandwidth_sel),
        .i_carr_en       (i_carr_en),
        .i_freq_fdata    (i_freq_fdata),
        .i_freq_ffram    (i_freq_ffram),
        .o_freq_txant    (o_freq_txant),
        .o_freq_tfram    (o_freq_tfram),
        .o_freq_tdata    (o_freq_tdata),
        .o_locked        (o_locked),
        .o_fram_err      (o_fram_err)
    );

    always #5 clk_491 = ~clk_491;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] tdata;
        logic              txant;
        logic              tfram;
        logic              locked;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Input history, indexed by cycle number.
    logic                fr_h  [MAXC];
    logic [3:0]          sel_h [MAXC];
    logic [NUM_CARR-1:0] en_h  [MAXC];
    logic [DATA_W-1:0]   dat_h [NUM_CARR][MAXC];
    int                  last_rst = -1;
    int                  cyc = -1;

    logic                cur_rst = 1'b0;
    logic [31:0]         cur_sel = 32'h4;
    logic [NUM_CARR-1:0] cur_en = '1;
    bit                  rand_data = 1'b0;

    // Most recent frame pulse at or before lim that no later reset has wiped.
    function automatic int last_frame(input int lim);
        for (int c = lim; c > last_rst; c--) begin
            if (c >= 0 && fr_h[c]) return c;
        end
        return -1;
    endfunction

    function automatic int period_of(input int f);
        case (sel_h[f+1])
            4'h1:       return 4 * RND;
            4'h2, 4'h3: return 2 * RND;
            default:    return RND;
        endcase
    endfunction

    // Slot counter value during cycle x, or -1 if no frame has landed yet.
    function automatic int model_cnt(input int x);
        int f;
        f = last_frame(x - 2);
        if (f < 0) return -1;
        return (x - 2 - f) % period_of(f);
    endfunction

    function automatic exp_t model(input int t);
        exp_t e;
        int   f, p, c, k, idx;
        e.cyc    = t;
        e.tdata  = '0;
        e.txant  = 1'b0;
        e.tfram  = 1'b0;
        e.locked = 1'b0;
        e.err    = 1'b0;
        if (last_rst >= t - 1) return e;
        e.tfram  = fr_h[t-2];
        e.locked = (last_frame(t - 2) >= 0);
        f = last_frame(t - 3);
        if (f >= 0) begin
            p = period_of(f);
            c = (t - 3 - f) % p;
            e.txant = (c == p - 1);
            k   = (c % RND) / BLK_LEN;
            idx = t - 2 - k * BLK_LEN;
            if (en_h[t-1][k] && idx >= 0) e.tdata = dat_h[k][idx];
`ifdef DL_TRANS_FRAM_CHK_EN
            e.err = fr_h[t-2] && (c != p - 1);
`endif
        end
        return e;
    endfunction

    task automatic step(input logic fr);
        logic [DATA_W-1:0] d;
        @(posedge clk_491);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        rst_491_n       = cur_rst;
        i_freq_ffram    = fr;
        i_bandwidth_sel = cur_sel;
        i_carr_en       = cur_en;
        for (int k = 0; k < NUM_CARR; k++) begin
            d = rand_data ? DATA_W'($urandom) : DATA_W'(32'h1000_0000 * (k + 1) + cyc);
            i_freq_fdata[k*DATA_W +: DATA_W] = d;
            dat_h[k][cyc] = d;
        end
        fr_h[cyc]  = fr;
        sel_h[cyc] = cur_sel[3:0];
        en_h[cyc]  = cur_en;
        if (!cur_rst) last_rst = cyc;
        exp_q.push_back(model(cyc));
    endtask

    // Issue a frame so that fram_d1 coincides with slot (period-1-back).
    task automatic frame_at(input int back);
        int guard;
        int p;
        step(1'b0);
        step(1'b0);
        p = period_of(last_frame(cyc));
        guard = 0;
        while (model_cnt(cyc + 2) != p - 1 - back && guard < 200) begin
            step(1'b0);
            guard++;
        end
        if (guard >= 200) begin
            n_chk++;
            $display("FAIL frame_align_bound cyc=%0d waited=%0d limit=200", cyc, guard);
        end
        step(1'b1);
    endtask

    task automatic check(input string name, input int c, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp_v);
        n_chk++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp_v);
    endtask

    exp_t mon_e;
    always @(negedge clk_491) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("tdata",  mon_e.cyc, o_freq_tdata, mon_e.tdata);
            check("txant",  mon_e.cyc, DATA_W'(o_freq_txant), DATA_W'(mon_e.txant));
            check("tfram",  mon_e.cyc, DATA_W'(o_freq_tfram), DATA_W'(mon_e.tfram));
            check("locked", mon_e.cyc, DATA_W'(o_locked), DATA_W'(mon_e.locked));
            check("err",    mon_e.cyc, DATA_W'(o_fram_err), DATA_W'(mon_e.err));
        end
    end

    initial begin
        // Reset, then default 1x mode with a frame at cycle 10.
        repeat (3) step(1'b0);
        cur_rst = 1'b1;
        while (cyc < 9) step(1'b0);
        step(1'b1);
        repeat (40) step(1'b0);
        frame_at(0);
        repeat (20) step(1'b0);
        frame_at(3);
        repeat (20) step(1'b0);

        // 4x mode, then a mid-frame switch to 2x that only applies at the next frame.
        cur_sel = 32'h1;
        step(1'b1);
        repeat (40) step(1'b0);
        cur_sel = 32'h2;
        repeat (60) step(1'b0);
        step(1'b1);
        repeat (40) step(1'b0);

        // Carrier 1 masked, random sample data.
        rand_data = 1'b1;
        cur_sel   = 32'h4;
        step(1'b1);
        cur_en = 2'b01;
        repeat (40) step(1'b0);
        cur_en = '1;

        // Reset mid-round, long unlocked stretch, then relock.
        cur_rst = 1'b0;
        repeat (2) step(1'b0);
        cur_rst = 1'b1;
        repeat (100) step(1'b0);
        step(1'b1);
        repeat (30) step(1'b0);

        // Random traffic: frames, modes, masks, upper sel bits and occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                cur_sel = $urandom;
                cur_sel[3:0] = 4'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 9) == 0) cur_en = NUM_CARR'($urandom);
            cur_rst = ($urandom_range(0, 149) != 0);
            step($urandom_range(0, 19) == 0);
        end
        cur_rst = 1'b1;
        repeat (5) step(1'b0);

        @(negedge clk_491);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
